// File: rtl/bmc_receiver.sv
// bmc_receiver: recovers bits from the oversampled photodiode comparator line,
// either as biphase-mark (edge-timed) or NRZ (mid-cell sampled). Optional macro RX_ERRCNT_EN adds err_count.
module bmc_receiver #(
  parameter int OVERSAMPLE = 8,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rin,
  input  logic        bmc_decode,
  output logic        dout,
  output logic        vout,
  output logic        locked,
  output logic        err
`ifdef RX_ERRCNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int CNT_W  = $clog2(4 * OVERSAMPLE);
  localparam int LEN_W  = CNT_W + 1;
  localparam int PH_W   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  RUN_MAX  = CNT_W'(4 * OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]  TOUT     = CNT_W'(2 * OVERSAMPLE + TOL);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]   PH_MID   = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {HUNT, BIT_START, MID_SEEN} state_e;
  typedef enum logic [1:0] {CLS_SHORT, CLS_LONG, CLS_ERR} cls_e;

  function automatic cls_e classify(input logic [LEN_W-1:0] len);
    int l;
    l = int'(len);
    if (l >= OVERSAMPLE - TOL && l <= OVERSAMPLE + TOL) return CLS_SHORT;
    if (l >= 2 * OVERSAMPLE - TOL && l <= 2 * OVERSAMPLE + TOL) return CLS_LONG;
    return CLS_ERR;
  endfunction

  function automatic logic [GOOD_W-1:0] sat_good(input logic [GOOD_W-1:0] v);
    return (v == GOOD_MAX) ? v : v + 1'b1;
  endfunction

  logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic              edge_det;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic              edge_p1_q, edge_p1_d;
  logic [LEN_W-1:0]  len_p1_q, len_p1_d;
  logic              tout_p1_q, tout_p1_d;
  logic              mode_q, mode_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  state_e            state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              dout_q, dout_d, vout_q, vout_d, err_q, err_d, locked_q, locked_d;
  logic              emit, emit_bit;
  cls_e              cls;
`ifdef RX_ERRCNT_EN
  logic [15:0]       err_count_q, err_count_d;
`endif

  always_comb begin
    s1_d      = rin;
    s2_d      = s1_q;
    s3_d      = s2_q;
    edge_det  = s2_q ^ s3_q;
    run_cnt_d = run_cnt_q;
    if (edge_det)                  run_cnt_d = '0;
    else if (run_cnt_q != RUN_MAX) run_cnt_d = run_cnt_q + 1'b1;
    // Stage p1: interval snapshot taken at the edge; the decision is made one cycle later.
    edge_p1_d = edge_det;
    len_p1_d  = {1'b0, run_cnt_q} + 1'b1;
    tout_p1_d = !edge_det && (run_cnt_q == TOUT);
    mode_d    = bmc_decode;
    phase_d   = (edge_det || phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    state_d   = state_q;
    good_d    = good_q;
    dout_d    = dout_q;
    vout_d    = 1'b0;
    err_d     = 1'b0;
    emit      = 1'b0;
    emit_bit  = 1'b0;
    cls       = classify(len_p1_q);

    if (bmc_decode != mode_q) begin
      state_d = HUNT;
      phase_d = '0;
      good_d  = '0;
    end else if (mode_q) begin
      if (edge_p1_q) begin
        case (state_q)
          HUNT: if (cls == CLS_LONG) state_d = BIT_START;
          BIT_START: begin
            if (cls == CLS_LONG) begin
              emit = 1'b1;
            end else if (cls == CLS_SHORT) begin
              state_d = MID_SEEN;
            end else begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          end
          MID_SEEN: begin
            if (cls == CLS_SHORT) begin
              emit     = 1'b1;
              emit_bit = 1'b1;
              state_d  = BIT_START;
            end else begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          end
          default: state_d = HUNT;
        endcase
      end else if (tout_p1_q && state_q != HUNT) begin
        err_d   = 1'b1;
        state_d = HUNT;
      end
    end else if (phase_q == PH_MID) begin
      emit     = 1'b1;
      emit_bit = s2_q;
    end

    if (emit) begin
      vout_d = 1'b1;
      dout_d = emit_bit;
      good_d = sat_good(good_q);
    end
    if (err_d) good_d = '0;
    locked_d = (good_d == GOOD_MAX);
`ifdef RX_ERRCNT_EN
    err_count_d = (err_d && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      run_cnt_q <= '0;
      edge_p1_q <= 1'b0;
      len_p1_q  <= '0;
      tout_p1_q <= 1'b0;
      mode_q    <= 1'b0;
      phase_q   <= '0;
      state_q   <= HUNT;
      good_q    <= '0;
      dout_q    <= 1'b0;
      vout_q    <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
`ifdef RX_ERRCNT_EN
      err_count_q <= '0;
`endif
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      run_cnt_q <= run_cnt_d;
      edge_p1_q <= edge_p1_d;
      len_p1_q  <= len_p1_d;
      tout_p1_q <= tout_p1_d;
      mode_q    <= mode_d;
      phase_q   <= phase_d;
      state_q   <= state_d;
      good_q    <= good_d;
      dout_q    <= dout_d;
      vout_q    <= vout_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
`ifdef RX_ERRCNT_EN
      err_count_q <= err_count_d;
`endif
    end
  end

  assign dout   = dout_q;
  assign vout   = vout_q;
  assign err    = err_q;
  assign locked = locked_q;
`ifdef RX_ERRCNT_EN
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_bmc_receiver.sv
// Directed bench for bmc_receiver: BMC and NRZ decode, jitter, timeout, reset and mode changes.
module tb_bmc_receiver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rin = 1'b0;
  logic bmc_decode = 1'b1;
  logic dout, vout, locked, err;
`ifdef RX_ERRCNT_EN
  logic [15:0] err_count;
`endif

  bmc_receiver dut (
    .clk(clk),
    .rst_n(rst_n),
    .rin(rin),
    .bmc_decode(bmc_decode),
    .dout(dout),
    .vout(vout),
    .locked(locked),
    .err(err)
`ifdef RX_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // One record per line transition: len = cycles until the next transition,
  // expectations are the strobes 3 cycles after this transition is first sampled.
  typedef struct {
    int len;
    bit v;
    bit d;
    bit e;
    bit lk;
  } vec_t;
  vec_t vecs[$];

  task automatic chk1(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s idx=%0d got=%b want=%b", name, idx, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s idx=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input int len, input bit v, input bit d, input bit e, input bit lk);
    vec_t t;
    t.len = len; t.v = v; t.d = d; t.e = e; t.lk = lk;
    vecs.push_back(t);
  endtask

  // 20 zeros then 1,0,1,1; the first transition is ignored and the second only aligns.
  task automatic load_a();
    vecs.delete();
    add(16, 0, 0, 0, 0);
    add(16, 0, 0, 0, 0);
    for (int i = 2; i <= 20; i++) add((i == 20) ? 8 : 16, 1, 0, 0, i >= 17);
    add(8, 0, 0, 0, 1);
    add(16, 1, 1, 0, 1);
    add(8, 1, 0, 0, 1);
    add(8, 0, 0, 0, 1);
    add(8, 1, 1, 0, 1);
    add(8, 0, 0, 0, 1);
    add(4, 1, 1, 0, 1);
  endtask

  // Jittered SHORT/LONG intervals, an 11-cycle error, relock, then LONG inside a cell.
  task automatic load_b();
    vecs.delete();
    add(16, 0, 0, 0, 0);
    add(14, 0, 0, 0, 0);
    add(18, 1, 0, 0, 0);
    add(6, 1, 0, 0, 0);
    add(10, 0, 0, 0, 0);
    add(10, 1, 1, 0, 0);
    add(6, 0, 0, 0, 0);
    add(11, 1, 1, 0, 0);
    add(16, 0, 0, 1, 0);
    add(16, 0, 0, 0, 0);
    add(8, 1, 0, 0, 0);
    add(16, 0, 0, 0, 0);
    add(16, 0, 0, 1, 0);
    add(16, 0, 0, 0, 0);
    add(16, 1, 0, 0, 0);
  endtask

  task automatic run_vecs(input string tag);
    int nv;
    int ne;
    foreach (vecs[i]) begin
      nv = 0;
      ne = 0;
      rin = ~rin;
      for (int c = 1; c <= vecs[i].len; c++) begin
        @(negedge clk);
        nv += int'(vout);
        ne += int'(err);
        if (c == 4) begin
          chk1({tag, "_vout"}, i, vout, vecs[i].v);
          if (vecs[i].v) chk1({tag, "_dout"}, i, dout, vecs[i].d);
          chk1({tag, "_err"}, i, err, vecs[i].e);
          chk1({tag, "_locked"}, i, locked, vecs[i].lk);
        end
      end
      chkn({tag, "_nvout"}, i, nv, int'(vecs[i].v));
      chkn({tag, "_nerr"}, i, ne, int'(vecs[i].e));
    end
  endtask

  task automatic idle(input int n, output int nv, output int ne);
    nv = 0;
    ne = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      nv += int'(vout);
      ne += int'(err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int ne;

    repeat (3) @(negedge clk);
    chk1("reset_dout", 0, dout, 1'b0);
    chk1("reset_vout", 0, vout, 1'b0);
    chk1("reset_locked", 0, locked, 1'b0);
    chk1("reset_err", 0, err, 1'b0);
    rst_n = 1'b1;
    idle(40, nv, ne);
    chkn("startup_vout", 0, nv, 0);
    load_a();
    run_vecs("a1");

    // Asynchronous reset while in MID_SEEN, with locked=1 and dout=1 held.
    repeat (4) @(negedge clk);
    rin = ~rin;
    repeat (4) @(negedge clk);
    chk1("mid_vout", 0, vout, 1'b0);
    chk1("mid_locked", 0, locked, 1'b1);
    chk1("mid_dout", 0, dout, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_dout", 0, dout, 1'b0);
    chk1("arst_vout", 0, vout, 1'b0);
    chk1("arst_locked", 0, locked, 1'b0);
    chk1("arst_err", 0, err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(40, nv, ne);
    chkn("post_reset_vout", 0, nv, 0);
    load_a();
    run_vecs("a2");

    // Line stuck after a bit boundary: timeout 19 cycles after the boundary edge.
    nv = 0;
    ne = 0;
    for (int c = 5; c <= 25; c++) begin
      @(negedge clk);
      nv += int'(vout);
      ne += int'(err);
      if (c == 22) begin
        chk1("stuck_locked_before", c, locked, 1'b1);
        chk1("stuck_err_before", c, err, 1'b0);
      end
      if (c == 23) begin
        chk1("stuck_err", c, err, 1'b1);
        chk1("stuck_locked", c, locked, 1'b0);
      end
    end
    chkn("stuck_nvout", 0, nv, 0);
    chkn("stuck_nerr", 0, ne, 1);

    idle(40, nv, ne);
    load_b();
    run_vecs("b");
`ifdef RX_ERRCNT_EN
    chkn("err_count", 0, int'(err_count), 3);
`endif

    // NRZ: bits 1,0,0,1 at 8 cycles each.
    bmc_decode = 1'b0;
    rin = 1'b0;
    idle(20, nv, ne);
    chkn("nrz_idle_err", 0, ne, 0);
    nv = 0;
    ne = 0;
    rin = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c >= 4) nv += int'(vout);
      ne += int'(err);
      if (c == 7)  begin chk1("nrz_vout", c, vout, 1'b1); chk1("nrz_dout", c, dout, 1'b1); end
      if (c == 15) begin chk1("nrz_vout", c, vout, 1'b1); chk1("nrz_dout", c, dout, 1'b0); end
      if (c == 23) begin chk1("nrz_vout", c, vout, 1'b1); chk1("nrz_dout", c, dout, 1'b0); end
      if (c == 31) begin chk1("nrz_vout", c, vout, 1'b1); chk1("nrz_dout", c, dout, 1'b1); end
      if (c == 8)  rin = 1'b0;
      if (c == 24) rin = 1'b1;
    end
    chkn("nrz_nvout", 0, nv, 4);
    chkn("nrz_nerr", 0, ne, 0);

    // Mode toggle while locked in BMC.
    bmc_decode = 1'b1;
    idle(40, nv, ne);
    load_a();
    run_vecs("a3");
    @(negedge clk);
    bmc_decode = 1'b0;
    @(negedge clk);
    chk1("msw_locked", 0, locked, 1'b0);
    chk1("msw_vout", 0, vout, 1'b0);
    bmc_decode = 1'b1;
    @(negedge clk);
    chk1("msw_vout2", 0, vout, 1'b0);
    chk1("msw_locked2", 0, locked, 1'b0);
    repeat (9) @(negedge clk);
    vecs.delete();
    add(16, 0, 0, 0, 0);
    add(8, 1, 0, 0, 0);
    run_vecs("msw");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bmc_receiver.md
Name: bmc_receiver

Overview:
- Receive-side counterpart of the optical link transmitter. Recovers bits from the oversampled photodiode comparator line.
- Two modes, selected by `bmc_decode`:
  - 1: biphase-mark decode with edge-timed clock recovery.
  - 0: NRZ mid-cell sampling.
- Emits one-cycle valid strobes with the decoded bit, plus lock and error status, to the downstream deframer.

Parameters:
- OVERSAMPLE, 8, clk cycles per transmitted half-cell. One transmitter `vin` period; a BMC bit is 2*OVERSAMPLE.
- TOL, 2, allowed ± jitter in cycles on each measured interval. Must be < OVERSAMPLE/2.
- LOCK_COUNT, 16, consecutive error-free decoded bits required before `locked` asserts.

Ports:
- clk  input  1  system clock; the only clock
- rst_n  input  1  reset, asynchronous, active-low
- rin  input  1  raw line input, asynchronous to clk
- bmc_decode  input  1  1 = BMC decode, 0 = NRZ sampling
- dout  output  1  decoded bit, valid when vout=1
- vout  output  1  one-cycle strobe per decoded bit
- locked  output  1  receiver aligned and stable
- err  output  1  one-cycle pulse on any framing/timing violation

Behaviour:
- Reset:
  - While rst_n=0, all flops clear asynchronously: dout=0, vout=0, locked=0, err=0, FSM=HUNT, counters=0.
  - Reset asserted mid-bit discards the partial bit; no vout is issued for it.
- Front end:
  - rin passes through a 2-flop synchronizer, then a third flop for edge detect.
  - edge = s2 XOR s3.
  - Line-to-edge latency is 2 cycles.
- Interval counter run_cnt:
  - Cleared on edge; otherwise increments, saturating at 4*OVERSAMPLE-1.
  - Measured interval len = run_cnt+1 at the edge.
- Classification, BMC mode:
  - SHORT if |len-OVERSAMPLE| <= TOL.
  - LONG if |len-2*OVERSAMPLE| <= TOL.
  - Otherwise ERR.
- BMC FSM (states HUNT, BIT_START, MID_SEEN):
  - HUNT: ignore SHORT. A LONG edge proves a bit boundary → BIT_START. No output is emitted.
  - BIT_START: LONG → emit 0, stay. SHORT → MID_SEEN. ERR → err pulse, HUNT.
  - MID_SEEN: SHORT → emit 1, BIT_START. LONG or ERR → err pulse, HUNT.
  - Timeout: in any non-HUNT state, run_cnt reaching 2*OVERSAMPLE+TOL without an edge → err pulse, HUNT.
- Output timing:
  - Emit means: vout=1 and dout=bit, registered in the cycle after the edge is detected.
  - vout therefore rises exactly 3 clk after the clk edge that first samples the bit-ending transition on rin.
  - vout never asserts on two consecutive cycles.
- NRZ mode:
  - Phase counter, modulo OVERSAMPLE, is cleared on edge.
  - When phase == OVERSAMPLE/2 - 1: emit dout=s2, vout=1.
  - A long run with no edges continues emitting one bit every OVERSAMPLE cycles.
  - err is never asserted in NRZ mode.
- Lock (good_cnt):
  - Increments on each emitted bit, saturating at LOCK_COUNT.
  - locked=1 while good_cnt == LOCK_COUNT.
  - Any err or entry to HUNT clears good_cnt and locked in the same cycle as err.
  - In NRZ mode, good_cnt clears only on a mode change.
- Mode change:
  - bmc_decode is registered; any change detected → FSM to HUNT, good_cnt, locked and phase cleared.
  - No vout in that cycle.
- Simultaneous events: edge and timeout in the same cycle → the edge wins and is classified normally.
- Output registering: dout holds its last value between strobes. vout, err and locked are registered with no combinational path from rin.

Optional Feature:
- Macro: RX_ERRCNT_EN.
- Defined:
  - Adds output port err_count [15:0], reset 0.
  - Increments on every err pulse and saturates at 16'hFFFF.
  - Clears only on reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-stream: assert rst_n=0 during a MID_SEEN half-cell → dout=0, vout=0, locked=0, err=0 immediately, with no clk edge needed. After release, no vout until the first LONG interval is seen.
- BMC decode (OVERSAMPLE=8, TOL=2):
  - Stimulus: 20 zeros, then 1,0,1,1.
  - vout pulses 16 cycles apart; each is 3 cycles after its bit-ending edge.
  - Payload dout = 1,0,1,1.
  - locked rises on the 16th emitted zero.
- Jitter: edge intervals of 6/10 (SHORT) and 14/18 (LONG) → all bits correct, err=0. An interval of 11 → single err pulse, locked=0, FSM in HUNT; relock after the next LONG.
- Line stuck high for 19 cycles after a bit boundary → err pulse at timeout, locked drops, no vout.
- NRZ mode: bmc_decode=0, bits 1,0,0,1 at 8 cycles each → vout every 8 cycles, dout = 1,0,0,1, err never asserted.
- Mode switch: toggle bmc_decode while locked in BMC → locked=0 the next cycle, no spurious vout, FSM=HUNT.
- With RX_ERRCNT_EN defined: 3 induced errors → err_count=3.
